// File: rtl/shift_sequencer_pkg.sv
// Shared types and sizing helpers for the shift_sequencer slice.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Counter must be able to hold any step count from 0 to the data width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Shift-step counter: synchronous clear, increment enable, terminal-count flag.
module shift_bit_counter
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SHIFT_COUNT = WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_VAL = (SHIFT_COUNT == 0) ? '0 : CW'(SHIFT_COUNT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  // A zero-step word never reaches SHIFT, so the flag is simply held low.
  assign last = (SHIFT_COUNT != 0) && (count == LAST_VAL);

endmodule

// File: rtl/shift_sequencer.sv
// Loads a word into the downstream shift register, then shifts it SHIFT_COUNT steps.
// Optional pause input enabled by defining SHIFT_SEQ_PAUSE_EN.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SHIFT_COUNT = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             sr_enable,
  output logic             sr_load,
  output logic             sr_shift_left,
  output logic [WIDTH-1:0] sr_datain,
  output logic             busy,
  output logic             done
`ifdef SHIFT_SEQ_PAUSE_EN
  ,
  input  logic             pause
`endif
);

  seq_state_t       state, state_d;
  logic             en_d, load_d, left_d, done_d, busy_d;
  logic [WIDTH-1:0] data_d;
  logic             cnt_clear, cnt_inc, cnt_last;
  logic             pause_i;

`ifdef SHIFT_SEQ_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  shift_bit_counter #(
    .WIDTH       (WIDTH),
    .SHIFT_COUNT (SHIFT_COUNT)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .last  (cnt_last)
  );

  assign in_ready = (state == IDLE);

  // Outputs are registered from next-state values; a SHIFT cycle is "active"
  // when the registered enable is high, so pause seen at an edge blanks the next cycle.
  always_comb begin
    state_d   = state;
    en_d      = 1'b0;
    load_d    = 1'b0;
    data_d    = '0;
    left_d    = sr_shift_left;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_d   = LOAD;
          en_d      = 1'b1;
          load_d    = 1'b1;
          data_d    = in_data;
          left_d    = in_msb_first;
          cnt_clear = 1'b1;
        end
      end
      LOAD: begin
        if (SHIFT_COUNT == 0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = SHIFT;
          en_d    = 1'b1;
        end
      end
      SHIFT: begin
        cnt_inc = sr_enable;
        if (sr_enable && cnt_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          en_d = !pause_i;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      sr_enable     <= 1'b0;
      sr_load       <= 1'b0;
      sr_shift_left <= 1'b0;
      sr_datain     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      sr_enable     <= en_d;
      sr_load       <= load_d;
      sr_shift_left <= left_d;
      sr_datain     <= data_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: schedule-queue reference model plus directed literal checks.
module tb_shift_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned SC = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_msb_first = 1'b0;
  logic         pause = 1'b0;
  logic         in_ready, sr_enable, sr_load, sr_shift_left, busy, done;
  logic [W-1:0] sr_datain;

  logic         v0 = 1'b0;
  logic [W-1:0] d0 = '0;
  logic         dir0 = 1'b0;
  logic         r0_ready, r0_en, r0_load, r0_left, r0_busy, r0_done;
  logic [W-1:0] r0_data;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(W), .SHIFT_COUNT(SC)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_msb_first(in_msb_first), .sr_enable(sr_enable),
    .sr_load(sr_load), .sr_shift_left(sr_shift_left), .sr_datain(sr_datain),
    .busy(busy), .done(done)
`ifdef SHIFT_SEQ_PAUSE_EN
    , .pause(pause)
`endif
  );

  shift_sequencer #(.WIDTH(W), .SHIFT_COUNT(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(v0), .in_ready(r0_ready),
    .in_data(d0), .in_msb_first(dir0), .sr_enable(r0_en),
    .sr_load(r0_load), .sr_shift_left(r0_left), .sr_datain(r0_data),
    .busy(r0_busy), .done(r0_done)
`ifdef SHIFT_SEQ_PAUSE_EN
    , .pause(1'b0)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Expected outputs for one clock cycle.
  typedef struct packed {
    logic         en, load, left;
    logic [W-1:0] data;
    logic         busy, done, ready, sh;
  } exp_t;

  function automatic exp_t idle_e(input logic dir);
    return '{en:1'b0, load:1'b0, left:dir, data:'0, busy:1'b0, done:1'b0, ready:1'b1, sh:1'b0};
  endfunction
  function automatic exp_t load_e(input logic [W-1:0] d, input logic dir);
    return '{en:1'b1, load:1'b1, left:dir, data:d, busy:1'b1, done:1'b0, ready:1'b0, sh:1'b0};
  endfunction
  function automatic exp_t shift_e(input logic dir, input logic en);
    return '{en:en, load:1'b0, left:dir, data:'0, busy:1'b1, done:1'b0, ready:1'b0, sh:1'b1};
  endfunction
  function automatic exp_t done_e(input logic dir);
    return '{en:1'b0, load:1'b0, left:dir, data:'0, busy:1'b1, done:1'b1, ready:1'b0, sh:1'b0};
  endfunction

  // Reference: an accepted word schedules LOAD, SC shift cycles and DONE;
  // a pause seen during a shift cycle inserts one blank shift cycle ahead of the rest.
  exp_t q[$];
  exp_t cur;
  logic mdir;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      mdir = 1'b0;
      cur  = idle_e(1'b0);
    end else begin
      if (cur.ready && in_valid) begin
        mdir = in_msb_first;
        q.push_back(load_e(in_data, in_msb_first));
        for (int i = 0; i < int'(SC); i++) q.push_back(shift_e(in_msb_first, 1'b1));
        q.push_back(done_e(in_msb_first));
      end else if (pause && cur.sh && q.size() > 0 && q[0].sh) begin
        q.push_front(shift_e(mdir, 1'b0));
      end
      cur = (q.size() > 0) ? q.pop_front() : idle_e(mdir);
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk1("m_enable", sr_enable, cur.en);
      chk1("m_load", sr_load, cur.load);
      chk1("m_shift_left", sr_shift_left, cur.left);
      chk8("m_datain", sr_datain, cur.data);
      chk1("m_busy", busy, cur.busy);
      chk1("m_done", done, cur.done);
      chk1("m_ready", in_ready, cur.ready);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int loads, dones;

    // Reset and idle state
    step(1);
    chk_on = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    chk1("t1_ready", in_ready, 1'b1);
    chk1("t1_busy", busy, 1'b0);
    chk1("t1_enable", sr_enable, 1'b0);
    chk1("t1_load", sr_load, 1'b0);
    chk1("t1_done", done, 1'b0);
    chk8("t1_datain", sr_datain, 8'h00);

    // Right shift of 8'b10110110
    in_valid = 1'b1; in_data = 8'hB6; in_msb_first = 1'b0;
    step(1);
    in_valid = 1'b0; in_data = 8'h00;
    chk1("t2_load", sr_load, 1'b1);
    chk8("t2_datain", sr_datain, 8'hB6);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk1("t2_enable", sr_enable, 1'b1);
      chk1("t2_left", sr_shift_left, 1'b0);
    end
    step(1);
    chk1("t2_done", done, 1'b1);
    step(1);
    chk1("t2_ready", in_ready, 1'b1);

    // Left shift, valid held so a second word follows immediately
    in_valid = 1'b1; in_data = 8'hB6; in_msb_first = 1'b1;
    step(1);
    chk1("t3_load", sr_load, 1'b1);
    in_data = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk1("t3_left", sr_shift_left, 1'b1);
    end
    step(1);
    chk1("t3_done", done, 1'b1);
    step(1);
    chk1("t3_ready", in_ready, 1'b1);
    step(1);
    in_valid = 1'b0;
    chk1("t3_load2", sr_load, 1'b1);
    chk8("t3_datain2", sr_datain, 8'h3C);
    step(11);

    // Reset during the 4th shift cycle
    in_valid = 1'b1; in_data = 8'h5A; in_msb_first = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk1("t4_enable", sr_enable, 1'b0);
    chk1("t4_left", sr_shift_left, 1'b0);
    chk1("t4_busy", busy, 1'b0);
    chk1("t4_ready", in_ready, 1'b1);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (done) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL t4_no_done: got %0d done pulses expected 0", dones);
    end

    // Input changes while busy are ignored
    in_valid = 1'b1; in_data = 8'h81; in_msb_first = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(3);
    in_valid = 1'b1; in_data = 8'hFF;
    step(1);
    in_valid = 1'b0;
    loads = 0; dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (sr_load) loads++;
      if (done) dones++;
      step(1);
    end
    n_checks++;
    if (loads != 0 || dones != 1) begin
      n_err++;
      $display("FAIL t5_ignore_busy: got loads=%0d dones=%0d expected loads=0 dones=1", loads, dones);
    end

`ifdef SHIFT_SEQ_PAUSE_EN
    // Pause held for three shift cycles stretches the word by three
    step(2);
    in_valid = 1'b1; in_data = 8'hC3; in_msb_first = 1'b0;
    step(1);
    in_valid = 1'b0;
    step(3);
    pause = 1'b1;
    step(1);
    chk1("t6_pause_en1", sr_enable, 1'b0);
    step(1);
    chk1("t6_pause_en2", sr_enable, 1'b0);
    step(1);
    pause = 1'b0;
    chk1("t6_pause_en3", sr_enable, 1'b0);
    step(1);
    chk1("t6_resume_en", sr_enable, 1'b1);
    step(5);
    chk1("t6_done", done, 1'b1);
    step(2);
`endif

    // Zero-step instance: LOAD then DONE
    v0 = 1'b1; d0 = 8'h77; dir0 = 1'b1;
    step(1);
    v0 = 1'b0;
    chk1("t7_load", r0_load, 1'b1);
    chk8("t7_datain", r0_data, 8'h77);
    chk1("t7_left", r0_left, 1'b1);
    chk1("t7_no_done", r0_done, 1'b0);
    step(1);
    chk1("t7_done", r0_done, 1'b1);
    chk1("t7_enable", r0_en, 1'b0);
    step(1);
    chk1("t7_ready", r0_ready, 1'b1);
    chk1("t7_busy", r0_busy, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 79) == 0);
      in_valid     = $urandom_range(0, 1) == 1;
      in_data      = W'($urandom);
      in_msb_first = $urandom_range(0, 1) == 1;
`ifdef SHIFT_SEQ_PAUSE_EN
      pause        = ($urandom_range(0, 3) == 0);
`endif
      step(1);
    end
    reset = 1'b0; in_valid = 1'b0; pause = 1'b0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
